// File: rtl/reg_bank_pkg.sv
// Shared types and saturation helpers for the reg_bank datapath register file.
package reg_bank_pkg;

    localparam int SAT_W = 64;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_SHIFT,
        OP_ACC,
        OP_LOAD
    } wr_op_e;

    function automatic logic signed [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

    // Operands arrive sign-extended; the sum gets one guard bit so it is exact.
    function automatic logic signed [SAT_W:0] exact_sum(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b
    );
        logic signed [SAT_W:0] s;
        s = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        return s;
    endfunction

    function automatic logic sat_flag(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] s, hi, lo;
        s  = exact_sum(a, b);
        hi = {1'b0, sat_max(w)};
        lo = {1'b1, sat_min(w)};
        return (s > hi) || (s < lo);
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_add_fn(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] s, hi, lo;
        s  = exact_sum(a, b);
        hi = {1'b0, sat_max(w)};
        lo = {1'b1, sat_min(w)};
        if (s > hi)
            return sat_max(w);
        else if (s < lo)
            return sat_min(w);
        return s[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Control, data and status bundle between the streams/MAC array and reg_bank.
interface reg_bank_if #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic                     i_clr;
    logic                     i_shift;
    logic                     i_acc;
    logic                     i_load;
    logic [AW-1:0]            i_addr;
    logic signed [WIDTH-1:0]  i_din;
    logic                     i_rd_en;
    logic [AW-1:0]            i_rd_addr;
    logic signed [WIDTH-1:0]  o_rd_data;
    logic                     o_rd_valid;
    logic [DEPTH*WIDTH-1:0]   o_q_all;
    logic                     o_filled;
    logic                     o_ovf;

    modport master (
        output i_clr, i_shift, i_acc, i_load, i_addr, i_din,
        output i_rd_en, i_rd_addr,
        input  o_rd_data, o_rd_valid, o_q_all, o_filled, o_ovf
    );

    modport slave (
        input  i_clr, i_shift, i_acc, i_load, i_addr, i_din,
        input  i_rd_en, i_rd_addr,
        output o_rd_data, o_rd_valid, o_q_all, o_filled, o_ovf
    );

endinterface

// File: rtl/reg_bank_sat_add.sv
// Combinational signed saturating adder; flags when the result was clipped.
module sat_add
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_sum,
    output logic                    o_sat
);

    logic signed [SAT_W-1:0] w_a;
    logic signed [SAT_W-1:0] w_b;

    assign w_a   = SAT_W'(i_a);
    assign w_b   = SAT_W'(i_b);
    assign o_sum = WIDTH'(sat_add_fn(w_a, w_b, WIDTH));
    assign o_sat = sat_flag(w_a, w_b, WIDTH);

endmodule

// File: rtl/reg_bank.sv
// Addressed/shiftable bank of signed registers with saturating accumulate,
// registered read port and fill/overflow status.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    reg_bank_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic signed [WIDTH-1:0] r_entry [DEPTH];
    logic [CW-1:0]           r_cnt;
    logic                    r_filled;
    logic                    r_ovf;
    logic signed [WIDTH-1:0] r_rd_data;
    logic                    r_rd_valid;

    logic                    w_addr_ok;
    logic                    w_rd_ok;
    logic [AW-1:0]           w_idx;
    logic [AW-1:0]           w_rd_idx;
    logic signed [WIDTH-1:0] w_sum;
    logic                    w_sat;
    wr_op_e                  w_op;

    assign w_addr_ok = {1'b0, bus.i_addr} < DEPTH_A;
    assign w_rd_ok   = {1'b0, bus.i_rd_addr} < DEPTH_A;
    assign w_idx     = w_addr_ok ? bus.i_addr : '0;
    assign w_rd_idx  = w_rd_ok ? bus.i_rd_addr : '0;

    sat_add #(.WIDTH(WIDTH)) u_sat (
        .i_a   (r_entry[w_idx]),
        .i_b   (bus.i_din),
        .o_sum (w_sum),
        .o_sat (w_sat)
    );

    // A higher-priority strobe with a bad address still swallows the others.
    always_comb begin
        w_op = OP_NONE;
        if (bus.i_clr)
            w_op = OP_CLR;
        else if (bus.i_shift)
            w_op = OP_SHIFT;
        else if (bus.i_acc)
            w_op = w_addr_ok ? OP_ACC : OP_NONE;
        else if (bus.i_load)
            w_op = w_addr_ok ? OP_LOAD : OP_NONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_entry[i] <= '0;
            r_cnt      <= '0;
            r_filled   <= 1'b0;
            r_ovf      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.i_rd_en;
            if (bus.i_rd_en)
                r_rd_data <= w_rd_ok ? r_entry[w_rd_idx] : '0;

            case (w_op)
                OP_CLR: begin
                    for (int i = 0; i < DEPTH; i++)
                        r_entry[i] <= '0;
                    r_cnt    <= '0;
                    r_filled <= 1'b0;
                    r_ovf    <= 1'b0;
                end
                OP_SHIFT: begin
                    r_entry[0] <= bus.i_din;
                    for (int i = 1; i < DEPTH; i++)
                        r_entry[i] <= r_entry[i-1];
                    if (r_cnt != FULL)
                        r_cnt <= r_cnt + CW'(1);
                    r_filled <= (r_cnt >= FULL - CW'(1));
                end
                OP_ACC: begin
                    r_entry[w_idx] <= w_sum;
                    if (w_sat)
                        r_ovf <= 1'b1;
                end
                OP_LOAD: r_entry[w_idx] <= bus.i_din;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_q
        assign bus.o_q_all[g*WIDTH +: WIDTH] = r_entry[g];
    end

    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_rd_valid = r_rd_valid;
    assign bus.o_filled   = r_filled;
    assign bus.o_ovf      = r_ovf;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: an 8-entry and a 6-entry instance share clock/reset.
module tb_reg_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_bank_if #(.WIDTH(20), .DEPTH(8)) b8 ();
    reg_bank_if #(.WIDTH(20), .DEPTH(6)) b6 ();

    reg_bank #(.WIDTH(20), .DEPTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
    reg_bank #(.WIDTH(20), .DEPTH(6)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));

    function automatic logic [19:0] e8(input int i);
        return b8.o_q_all[i*20 +: 20];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle8;
        b8.i_clr = 0; b8.i_shift = 0; b8.i_acc = 0; b8.i_load = 0;
        b8.i_addr = '0; b8.i_din = '0; b8.i_rd_en = 0; b8.i_rd_addr = '0;
    endtask

    task automatic idle6;
        b6.i_clr = 0; b6.i_shift = 0; b6.i_acc = 0; b6.i_load = 0;
        b6.i_addr = '0; b6.i_din = '0; b6.i_rd_en = 0; b6.i_rd_addr = '0;
    endtask

    task automatic test_reset;
        total++;
        if (b8.o_q_all !== '0 || b8.o_rd_valid !== 0 || b8.o_filled !== 0 || b8.o_ovf !== 0) begin
            bad++;
            $display("FAIL reset_state q=%h rv=%b f=%b ovf=%b want all 0",
                     b8.o_q_all, b8.o_rd_valid, b8.o_filled, b8.o_ovf);
        end
        b8.i_load = 1; b8.i_addr = 0; b8.i_din = 20'h7FFFF;
        step;
        idle8; b8.i_acc = 1; b8.i_addr = 0; b8.i_din = 20'h00001;
        step;
        idle8; b8.i_rd_en = 1; b8.i_load = 1; b8.i_addr = 4; b8.i_din = 20'h00444;
        step;
        total++;
        if (b8.o_ovf !== 1 || b8.o_rd_valid !== 1 || e8(4) !== 20'h00444) begin
            bad++;
            $display("FAIL reset_setup ovf=%b rv=%b e4=%h want 1 1 00444",
                     b8.o_ovf, b8.o_rd_valid, e8(4));
        end
        idle8; b8.i_shift = 1; b8.i_din = 20'h0ABCD; b8.i_rd_en = 1;
        #2 rst = 1;
        #1;
        total++;
        if (b8.o_q_all !== '0 || b8.o_rd_valid !== 0 || b8.o_filled !== 0 ||
            b8.o_ovf !== 0 || b8.o_rd_data !== 0) begin
            bad++;
            $display("FAIL async_reset q=%h rv=%b f=%b ovf=%b rd=%h want all 0",
                     b8.o_q_all, b8.o_rd_valid, b8.o_filled, b8.o_ovf, b8.o_rd_data);
        end
        rst = 0;
        idle8;
        step;
    endtask

    task automatic test_load_read;
        b8.i_load = 1; b8.i_addr = 3; b8.i_din = 20'h12345;
        step;
        total++;
        if (e8(3) !== 20'h12345) begin
            bad++; $display("FAIL load_e3 got=%h want=12345", e8(3));
        end
        idle8; b8.i_rd_en = 1; b8.i_rd_addr = 3;
        step;
        total++;
        if (b8.o_rd_data !== 20'h12345 || b8.o_rd_valid !== 1) begin
            bad++; $display("FAIL read_e3 got=%h/%b want=12345/1", b8.o_rd_data, b8.o_rd_valid);
        end
        idle8;
        step;
        total++;
        if (b8.o_rd_valid !== 0 || b8.o_rd_data !== 20'h12345) begin
            bad++; $display("FAIL read_hold got=%h/%b want=12345/0", b8.o_rd_data, b8.o_rd_valid);
        end
        b8.i_load = 1; b8.i_addr = 3; b8.i_din = 20'h00001;
        b8.i_rd_en = 1; b8.i_rd_addr = 3;
        step;
        total++;
        if (b8.o_rd_data !== 20'h12345 || b8.o_rd_valid !== 1 || e8(3) !== 20'h00001) begin
            bad++;
            $display("FAIL rd_before_wr got=%h/%b e3=%h want=12345/1 e3=00001",
                     b8.o_rd_data, b8.o_rd_valid, e8(3));
        end
        idle8;
        step;
    endtask

    task automatic test_shift_fill;
        b8.i_clr = 1;
        step;
        idle8;
        for (int k = 1; k <= 8; k++) begin
            b8.i_shift = 1; b8.i_din = 20'(k);
            step;
            total++;
            if (b8.o_filled !== (k == 8)) begin
                bad++; $display("FAIL filled_k%0d got=%b want=%b", k, b8.o_filled, k == 8);
            end
        end
        total++;
        if (e8(0) !== 20'd8 || e8(3) !== 20'd5 || e8(7) !== 20'd1) begin
            bad++;
            $display("FAIL shift_order e0=%h e3=%h e7=%h want 8 5 1", e8(0), e8(3), e8(7));
        end
        b8.i_din = 20'd9;
        step;
        total++;
        if (e8(0) !== 20'd9 || e8(7) !== 20'd2 || b8.o_filled !== 1) begin
            bad++;
            $display("FAIL shift_9th e0=%h e7=%h f=%b want 9 2 1", e8(0), e8(7), b8.o_filled);
        end
        idle8;
    endtask

    task automatic test_acc_sat;
        b8.i_clr = 1;
        step;
        idle8; b8.i_load = 1; b8.i_addr = 0; b8.i_din = 20'h7FFF0;
        step;
        idle8; b8.i_acc = 1; b8.i_addr = 0; b8.i_din = 20'h00020;
        step;
        total++;
        if (e8(0) !== 20'h7FFFF || b8.o_ovf !== 1) begin
            bad++; $display("FAIL acc_pos_sat e0=%h ovf=%b want 7FFFF 1", e8(0), b8.o_ovf);
        end
        idle8; b8.i_load = 1; b8.i_addr = 1; b8.i_din = 20'h80005;
        step;
        idle8; b8.i_acc = 1; b8.i_addr = 1; b8.i_din = -20'sd16;
        step;
        total++;
        if (e8(1) !== 20'h80000) begin
            bad++; $display("FAIL acc_neg_sat e1=%h want 80000", e8(1));
        end
        b8.i_addr = 2; b8.i_din = 20'd5;
        step;
        total++;
        if (e8(2) !== 20'd5 || b8.o_ovf !== 1) begin
            bad++; $display("FAIL acc_plain e2=%h ovf=%b want 00005 1", e8(2), b8.o_ovf);
        end
        b8.i_din = -20'sd7;
        step;
        total++;
        if (e8(2) !== 20'hFFFFE) begin
            bad++; $display("FAIL acc_negative e2=%h want FFFFE", e8(2));
        end
        idle8;
    endtask

    task automatic test_priority;
        for (int k = 0; k < 8; k++) begin
            b8.i_shift = 1; b8.i_din = 20'h00011;
            step;
        end
        total++;
        if (b8.o_filled !== 1 || b8.o_ovf !== 1) begin
            bad++; $display("FAIL prio_setup f=%b ovf=%b want 1 1", b8.o_filled, b8.o_ovf);
        end
        idle8; b8.i_clr = 1; b8.i_shift = 1; b8.i_load = 1; b8.i_addr = 0; b8.i_din = 20'h00777;
        step;
        total++;
        if (b8.o_q_all !== '0 || b8.o_filled !== 0 || b8.o_ovf !== 0) begin
            bad++;
            $display("FAIL prio_clr q=%h f=%b ovf=%b want 0 0 0", b8.o_q_all, b8.o_filled, b8.o_ovf);
        end
        idle8; b8.i_shift = 1; b8.i_load = 1; b8.i_addr = 5; b8.i_din = 20'h000AA;
        step;
        total++;
        if (e8(0) !== 20'h000AA || e8(5) !== 20'h0) begin
            bad++; $display("FAIL prio_shift e0=%h e5=%h want 000AA 00000", e8(0), e8(5));
        end
        idle8; b8.i_load = 1; b8.i_addr = 3; b8.i_din = 20'd10;
        step;
        b8.i_acc = 1; b8.i_din = 20'd1;
        step;
        total++;
        if (e8(3) !== 20'd11) begin
            bad++; $display("FAIL prio_acc e3=%h want 0000B", e8(3));
        end
        idle8;
    endtask

    task automatic test_out_of_range;
        logic [119:0] exp6;
        exp6 = '0;
        exp6[2*20 +: 20] = 20'h00022;
        b6.i_load = 1; b6.i_addr = 2; b6.i_din = 20'h00022;
        step;
        idle6; b6.i_load = 1; b6.i_addr = 7; b6.i_din = 20'h00099;
        step;
        total++;
        if (b6.o_q_all !== exp6) begin
            bad++; $display("FAIL oor_load q=%h want=%h", b6.o_q_all, exp6);
        end
        idle6; b6.i_acc = 1; b6.i_addr = 6; b6.i_din = 20'h7FFFF;
        step;
        total++;
        if (b6.o_q_all !== exp6 || b6.o_ovf !== 0) begin
            bad++; $display("FAIL oor_acc q=%h ovf=%b want=%h 0", b6.o_q_all, b6.o_ovf, exp6);
        end
        idle6; b6.i_rd_en = 1; b6.i_rd_addr = 2;
        step;
        total++;
        if (b6.o_rd_data !== 20'h00022 || b6.o_rd_valid !== 1) begin
            bad++; $display("FAIL b2b_rd2 got=%h/%b want=00022/1", b6.o_rd_data, b6.o_rd_valid);
        end
        b6.i_rd_addr = 7;
        step;
        total++;
        if (b6.o_rd_data !== 20'h0 || b6.o_rd_valid !== 1) begin
            bad++; $display("FAIL oor_read got=%h/%b want=00000/1", b6.o_rd_data, b6.o_rd_valid);
        end
        b6.i_rd_addr = 2;
        step;
        total++;
        if (b6.o_rd_data !== 20'h00022 || b6.o_rd_valid !== 1) begin
            bad++; $display("FAIL b2b_rd2_again got=%h/%b want=00022/1", b6.o_rd_data, b6.o_rd_valid);
        end
        idle6;
        step;
    endtask

    initial begin
        idle8;
        idle6;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset;
        test_load_read;
        test_shift_fill;
        test_acc_sat;
        test_priority;
        test_out_of_range;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
